// File: rtl/block_ram_sdp_fwd.sv
// Simple dual-port RAM with per-column write enables and same-address read/write forwarding.
// Read latency RD_LATENCY (1 or 2) clocks; no backpressure, one read accepted every cycle.
module block_ram_sdp_fwd #(
  parameter int ADDRS_WIDTH = 12,
  parameter int NB_COL      = 8,
  parameter int COL_WIDTH   = 8,
  parameter int RD_LATENCY  = 1,
  parameter int BYPASS      = 1
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic                        wren,
  input  logic [NB_COL-1:0]           bwren,
  input  logic [ADDRS_WIDTH-1:0]      wraddrs,
  input  logic [NB_COL*COL_WIDTH-1:0] wrdata,
  input  logic                        rden,
  input  logic [ADDRS_WIDTH-1:0]      rdaddrs,
  output logic [NB_COL*COL_WIDTH-1:0] rddata,
  output logic                        rdvalid,
  output logic                        collision
);

  localparam int W     = NB_COL * COL_WIDTH;
  localparam int DEPTH = 2 ** ADDRS_WIDTH;

  if (!(RD_LATENCY == 1 || RD_LATENCY == 2)) begin : g_bad_latency
    $error("block_ram_sdp_fwd: RD_LATENCY must be 1 or 2");
  end

  // Array is never reset; the declaration initialiser matches the bitstream's all-zero init.
  logic [W-1:0] mem [DEPTH] = '{default: '0};

  logic         hit;
  logic [W-1:0] fwd_word;
  logic [W-1:0] s1_data;
  logic         s1_valid;
  logic         s1_coll;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB_COL; i++) begin
      if (RESETn && wren && bwren[i]) begin
        mem[wraddrs][i*COL_WIDTH +: COL_WIDTH] <= wrdata[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  assign hit = rden && wren && (rdaddrs == wraddrs) && (|bwren);

  // Read-first is the natural array behaviour; write-first overlays the enabled columns.
  always_comb begin
    fwd_word = mem[rdaddrs];
    if (BYPASS != 0 && hit) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (bwren[i]) begin
          fwd_word[i*COL_WIDTH +: COL_WIDTH] = wrdata[i*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= rden;
      s1_coll  <= hit;
      if (rden) begin
        s1_data <= fwd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_coll;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        out_data  <= '0;
        out_valid <= 1'b0;
        out_coll  <= 1'b0;
      end else begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_data;
          out_coll <= s1_coll;
        end
      end
    end

    assign rddata    = out_data;
    assign rdvalid   = out_valid;
    assign collision = out_coll;
  end else begin : g_lat1
    assign rddata    = s1_data;
    assign rdvalid   = s1_valid;
    assign collision = s1_coll;
  end

endmodule

// File: tb/tb_block_ram_sdp_fwd.sv
// Directed bench: three instances cover write-first/latency-1, read-first/latency-2 and a 16-deep array.
module tb_block_ram_sdp_fwd;

  logic        clk;
  logic        rst_n;
  logic        wren;
  logic [7:0]  bwren;
  logic [11:0] wraddrs;
  logic [63:0] wrdata;
  logic        rden;
  logic [11:0] rdaddrs;

  logic [63:0] rddata_a, rddata_b, rddata_c;
  logic        rdvalid_a, rdvalid_b, rdvalid_c;
  logic        coll_a, coll_b, coll_c;

  int tests;
  int failed;

  block_ram_sdp_fwd #(.ADDRS_WIDTH(12), .NB_COL(8), .COL_WIDTH(8), .RD_LATENCY(1), .BYPASS(1)) u_a (
    .CLK(clk), .RESETn(rst_n), .wren(wren), .bwren(bwren), .wraddrs(wraddrs), .wrdata(wrdata),
    .rden(rden), .rdaddrs(rdaddrs), .rddata(rddata_a), .rdvalid(rdvalid_a), .collision(coll_a)
  );

  block_ram_sdp_fwd #(.ADDRS_WIDTH(12), .NB_COL(8), .COL_WIDTH(8), .RD_LATENCY(2), .BYPASS(0)) u_b (
    .CLK(clk), .RESETn(rst_n), .wren(wren), .bwren(bwren), .wraddrs(wraddrs), .wrdata(wrdata),
    .rden(rden), .rdaddrs(rdaddrs), .rddata(rddata_b), .rdvalid(rdvalid_b), .collision(coll_b)
  );

  block_ram_sdp_fwd #(.ADDRS_WIDTH(4), .NB_COL(8), .COL_WIDTH(8), .RD_LATENCY(1), .BYPASS(1)) u_c (
    .CLK(clk), .RESETn(rst_n), .wren(wren), .bwren(bwren), .wraddrs(wraddrs[3:0]), .wrdata(wrdata),
    .rden(rden), .rdaddrs(rdaddrs[3:0]), .rddata(rddata_c), .rdvalid(rdvalid_c), .collision(coll_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, failed);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wren = 1'b0; bwren = 8'h00; wraddrs = '0; wrdata = '0;
    rden = 1'b0; rdaddrs = '0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
    wren = 1'b1; bwren = be; wraddrs = a; wrdata = d;
    tick();
    wren = 1'b0; bwren = 8'h00;
  endtask

  task automatic test_reset;
    tests++; if (rddata_a !== 64'h0 || rdvalid_a !== 1'b0 || coll_a !== 1'b0) begin failed++; $display("FAIL reset_a got d=%h v=%b c=%b exp 0/0/0", rddata_a, rdvalid_a, coll_a); end
    tests++; if (rddata_b !== 64'h0 || rdvalid_b !== 1'b0 || coll_b !== 1'b0) begin failed++; $display("FAIL reset_b got d=%h v=%b c=%b exp 0/0/0", rddata_b, rdvalid_b, coll_b); end
    tests++; if (rddata_c !== 64'h0 || rdvalid_c !== 1'b0 || coll_c !== 1'b0) begin failed++; $display("FAIL reset_c got d=%h v=%b c=%b exp 0/0/0", rddata_c, rdvalid_c, coll_c); end
  endtask

  task automatic test_basic;
    do_write(12'h005, 64'h0123456789ABCDEF, 8'hFF);
    rden = 1'b1; rdaddrs = 12'h005;
    tick();
    rden = 1'b0;
    tests++; if (rdvalid_a !== 1'b1 || rddata_a !== 64'h0123456789ABCDEF || coll_a !== 1'b0) begin failed++; $display("FAIL basic_a got v=%b d=%h c=%b exp 1/0123456789abcdef/0", rdvalid_a, rddata_a, coll_a); end
    tests++; if (rdvalid_b !== 1'b0) begin failed++; $display("FAIL basic_b_early got v=%b exp 0", rdvalid_b); end
    tick();
    tests++; if (rdvalid_a !== 1'b0) begin failed++; $display("FAIL basic_a_drop got v=%b exp 0", rdvalid_a); end
    tests++; if (rdvalid_b !== 1'b1 || rddata_b !== 64'h0123456789ABCDEF || coll_b !== 1'b0) begin failed++; $display("FAIL basic_b got v=%b d=%h c=%b exp 1/0123456789abcdef/0", rdvalid_b, rddata_b, coll_b); end
  endtask

  task automatic test_columns;
    do_write(12'h005, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    rden = 1'b1; rdaddrs = 12'h005;
    tick();
    rden = 1'b0;
    tests++; if (rddata_a !== 64'h01234567FFFFFFFF) begin failed++; $display("FAIL columns_a got %h exp 01234567ffffffff", rddata_a); end
    tick();
    tests++; if (rddata_b !== 64'h01234567FFFFFFFF) begin failed++; $display("FAIL columns_b got %h exp 01234567ffffffff", rddata_b); end
  endtask

  task automatic test_forwarding;
    do_write(12'h010, 64'h1111111111111111, 8'hFF);
    wren = 1'b1; bwren = 8'hF0; wraddrs = 12'h010; wrdata = 64'h2222222222222222;
    rden = 1'b1; rdaddrs = 12'h010;
    tick();
    wren = 1'b0; bwren = 8'h00;
    tests++; if (rddata_a !== 64'h2222222211111111 || coll_a !== 1'b1) begin failed++; $display("FAIL fwd_bypass got d=%h c=%b exp 2222222211111111/1", rddata_a, coll_a); end
    tick();
    rden = 1'b0;
    tests++; if (rdvalid_b !== 1'b1 || rddata_b !== 64'h1111111111111111 || coll_b !== 1'b1) begin failed++; $display("FAIL fwd_readfirst got v=%b d=%h c=%b exp 1/1111111111111111/1", rdvalid_b, rddata_b, coll_b); end
    tests++; if (rddata_a !== 64'h2222222211111111 || coll_a !== 1'b0) begin failed++; $display("FAIL fwd_bypass_next got d=%h c=%b exp 2222222211111111/0", rddata_a, coll_a); end
    tick();
    tests++; if (rdvalid_b !== 1'b1 || rddata_b !== 64'h2222222211111111 || coll_b !== 1'b0) begin failed++; $display("FAIL fwd_readfirst_next got v=%b d=%h c=%b exp 1/2222222211111111/0", rdvalid_b, rddata_b, coll_b); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_q [4];
    exp_q = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    for (int i = 0; i < 4; i++) do_write(12'(i), exp_q[i], 8'hFF);
    for (int k = 0; k < 4; k++) begin
      rden = 1'b1; rdaddrs = 12'(k);
      tick();
      tests++; if (rdvalid_a !== 1'b1 || rddata_a !== exp_q[k]) begin failed++; $display("FAIL stream_a[%0d] got v=%b d=%h exp 1/%h", k, rdvalid_a, rddata_a, exp_q[k]); end
      if (k == 0) begin
        tests++; if (rdvalid_b !== 1'b0) begin failed++; $display("FAIL stream_b_early got v=%b exp 0", rdvalid_b); end
      end else begin
        tests++; if (rdvalid_b !== 1'b1 || rddata_b !== exp_q[k-1]) begin failed++; $display("FAIL stream_b[%0d] got v=%b d=%h exp 1/%h", k-1, rdvalid_b, rddata_b, exp_q[k-1]); end
      end
    end
    rden = 1'b0;
    tick();
    tests++; if (rdvalid_b !== 1'b1 || rddata_b !== 64'hA3) begin failed++; $display("FAIL stream_b[3] got v=%b d=%h exp 1/a3", rdvalid_b, rddata_b); end
    tick();
    tests++; if (rdvalid_b !== 1'b0 || rddata_b !== 64'hA3) begin failed++; $display("FAIL stream_b_hold got v=%b d=%h exp 0/a3", rdvalid_b, rddata_b); end
  endtask

  task automatic test_reset_midread;
    rden = 1'b1; rdaddrs = 12'h005;
    tick();
    rden = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (rddata_b !== 64'h0 || rdvalid_b !== 1'b0 || coll_b !== 1'b0) begin failed++; $display("FAIL midreset_b got d=%h v=%b c=%b exp 0/0/0", rddata_b, rdvalid_b, coll_b); end
    tests++; if (rddata_a !== 64'h0 || rdvalid_a !== 1'b0) begin failed++; $display("FAIL midreset_a got d=%h v=%b exp 0/0", rddata_a, rdvalid_a); end
    wren = 1'b1; bwren = 8'hFF; wraddrs = 12'h005; wrdata = 64'hDEADBEEFDEADBEEF;
    rden = 1'b1; rdaddrs = 12'h005;
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    tests++; if (rdvalid_b !== 1'b0 || rdvalid_a !== 1'b0) begin failed++; $display("FAIL reset_edge_read got va=%b vb=%b exp 0/0", rdvalid_a, rdvalid_b); end
    rden = 1'b1; rdaddrs = 12'h005;
    tick();
    rden = 1'b0;
    tests++; if (rddata_a !== 64'h01234567FFFFFFFF) begin failed++; $display("FAIL preserved_a got %h exp 01234567ffffffff", rddata_a); end
    tick();
    tests++; if (rdvalid_b !== 1'b1 || rddata_b !== 64'h01234567FFFFFFFF) begin failed++; $display("FAIL preserved_b got v=%b d=%h exp 1/01234567ffffffff", rdvalid_b, rddata_b); end
  endtask

  task automatic test_boundary;
    do_write(12'h000, 64'hC0C0C0C0C0C0C0C0, 8'hFF);
    do_write(12'h00F, 64'hF0F0F0F0F0F0F0F0, 8'hFF);
    rden = 1'b1; rdaddrs = 12'h000;
    tick();
    tests++; if (rdvalid_c !== 1'b1 || rddata_c !== 64'hC0C0C0C0C0C0C0C0) begin failed++; $display("FAIL boundary_lo got v=%b d=%h exp 1/c0c0c0c0c0c0c0c0", rdvalid_c, rddata_c); end
    rdaddrs = 12'h00F;
    tick();
    rden = 1'b0;
    tests++; if (rdvalid_c !== 1'b1 || rddata_c !== 64'hF0F0F0F0F0F0F0F0) begin failed++; $display("FAIL boundary_hi got v=%b d=%h exp 1/f0f0f0f0f0f0f0f0", rdvalid_c, rddata_c); end
    tests++; if (rddata_a !== 64'hF0F0F0F0F0F0F0F0 || coll_a !== 1'b0) begin failed++; $display("FAIL boundary_a got d=%h c=%b exp f0f0f0f0f0f0f0f0/0", rddata_a, coll_a); end
    wren = 1'b1; bwren = 8'hFF; wraddrs = 12'h001; wrdata = 64'h5555555555555555;
    rden = 1'b1; rdaddrs = 12'h00F;
    tick();
    idle();
    tests++; if (rddata_c !== 64'hF0F0F0F0F0F0F0F0 || coll_c !== 1'b0) begin failed++; $display("FAIL diff_addr got d=%h c=%b exp f0f0f0f0f0f0f0f0/0", rddata_c, coll_c); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    idle();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_columns();
    test_forwarding();
    test_back_to_back();
    test_reset_midread();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/block_ram_sdp_fwd.md
# block_ram_sdp_fwd

Parametrised simple dual-port block RAM with per-column write enables, selectable 1- or 2-cycle read latency, read-valid tracking and same-address read/write forwarding. It is the general-purpose successor to the fixed 64-bit SDP RAM. It serves as the shared storage primitive for neuron-state, weight and spike-queue memories in the compute engine, where consumers need a qualified read stream and deterministic read-during-write results.

## Interface
- ADDRS_WIDTH, 12: address width; depth = 2**ADDRS_WIDTH words.
- NB_COL, 8: number of write-enable columns per word.
- COL_WIDTH, 8: bits per column; word width W = NB_COL*COL_WIDTH.
- RD_LATENCY, 1: read latency in clocks; legal values 1 or 2, other values are an elaboration error.
- BYPASS, 1: 1 = same-address read returns newly written columns (write-first per column); 0 = returns old contents (read-first).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- wren  input  1  write strobe.
- bwren  input  NB_COL  column enables; bit i qualifies wrdata[(i+1)*COL_WIDTH-1:i*COL_WIDTH].
- wraddrs  input  ADDRS_WIDTH  write address.
- wrdata  input  W  write data.
- rden  input  1  read strobe.
- rdaddrs  input  ADDRS_WIDTH  read address.
- rddata  output  W  read data.
- rdvalid  output  1  rddata carries the result of a read issued RD_LATENCY cycles earlier.
- collision  output  1  registered flag, aligned with rdvalid: the returned read hit the same-cycle write address with wren high and at least one bwren bit set.

## Operation
- Write: at a rising edge with wren=1, each column i with bwren[i]=1 is stored at wraddrs. Columns with bwren[i]=0 are unchanged. wren=0 or bwren=0 writes nothing.
- Read stage 1: at a rising edge with rden=1, the word at rdaddrs is captured into the stage-1 data register and s1_valid is set to 1. With rden=0, the stage-1 data register holds and s1_valid is cleared. wren does not enable the read port.
- Forwarding: a hit is rden & wren & (rdaddrs==wraddrs) & |bwren.
  - BYPASS=1: captured column i = bwren[i] ? wrdata column i : stored column i.
  - BYPASS=0: stored (pre-write) word captured.
  - collision is registered as the hit bit in both modes.
- RD_LATENCY=1: rddata = stage-1 register; rdvalid = s1_valid; collision from stage 1.
- RD_LATENCY=2: the output register loads the stage-1 data and collision when s1_valid=1 and holds otherwise. rdvalid = s1_valid delayed one cycle.
- rddata holds its last value while rdvalid=0; consumers ignore it.
- Memory contents are not reset. At power-up the array is initialised to all zeros in simulation and by bitstream init; no INIT_FILE is supported.
- Reset (RESETn=0, asynchronous): stage-1 and output data registers go to 0, and s1_valid, rdvalid and collision go to 0. In-flight reads are discarded. Array contents are preserved. A write or read coinciding with a reset-asserted edge is ignored.

## Timing
- Write commits at edge N. A read of the same address issued at edge N+1 or later returns the new data in both modes.
- Read issued at edge N: data and rdvalid=1 appear after edge N+RD_LATENCY-1, i.e. during cycle N+1 for latency 1 and cycle N+2 for latency 2. collision aligns with rdvalid.
- Back-to-back reads give one result per cycle with no bubbles. rdvalid is a one-to-one delayed copy of rden.
- Address wrap: addresses are modulo depth with no out-of-range case. Address 0 and 2**ADDRS_WIDTH-1 behave identically to others.
- Simultaneous read and write to different addresses: fully independent, collision=0.
- Reset release: the first rden sampled at an edge with RESETn=1 produces normal output after RD_LATENCY edges.

## Test plan
- Basic read/write, NB_COL=8, COL_WIDTH=8, RD_LATENCY=1: write 0x0123456789ABCDEF to address 0x005 with bwren=0xFF, then read 0x005 one cycle later -> rddata=0x0123456789ABCDEF with rdvalid=1 exactly one cycle after the read edge, collision=0.
- Column enables: address 0x005 holds 0x0123456789ABCDEF; write 0xFFFFFFFFFFFFFFFF with bwren=0x0F, then read -> 0x01234567FFFFFFFF.
- Read-during-write forwarding, address 0x010 holding 0x1111111111111111:
  - BYPASS=1: same-edge write 0x2222222222222222 with bwren=0xF0 and read -> rddata=0x2222222211111111, collision=1.
  - BYPASS=0: same stimulus -> rddata=0x1111111111111111, collision=1; a read the next cycle returns 0x2222222211111111 with collision=0.
- RD_LATENCY=2 streaming: issue reads on 4 consecutive edges to addresses 0x000 through 0x003, which hold 0xA0 through 0xA3 -> rdvalid high for 4 consecutive cycles starting 2 edges after the first read, with data 0xA0, 0xA1, 0xA2, 0xA3 in order. rddata holds 0xA3 afterwards with rdvalid=0.
- Reset mid-read with RD_LATENCY=2: issue a read, then assert RESETn=0 between the two edges -> rddata=0, rdvalid=0 and collision=0 immediately (asynchronously). After release, a read of the same address returns the pre-reset stored value, showing the array is preserved.
- Address boundaries with ADDRS_WIDTH=4: write distinct values to addresses 0x0 and 0xF, then read both -> correct values returned and no aliasing.
